// File: rtl/dmem_bus_arbiter_if.sv
// Requester-side bus for the data-memory arbiter.
// One instance per master; the arbiter takes the slave view.
interface dmem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  we;
  logic [DATA_W/8-1:0]   wmask;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req,
    output we,
    output wmask,
    output addr,
    output wdata,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  wmask,
    input  addr,
    input  wdata,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter for the shared data RAM / IO port.
// Bit 22 of the address selects IO; reads return one cycle later.
module dmem_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  dmem_bus_arbiter_if.slave   m0,
  dmem_bus_arbiter_if.slave   m1,
  output logic [DATA_W/8-1:0] ram_wmask,
  output logic                io_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  input  logic [DATA_W-1:0]   io_rdata,
  output logic [3:0]          starve_cnt
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);
  localparam int         IO_BIT  = 22;

  typedef struct packed {
    logic valid;
    logic id;
    logic tgt;
  } rsp_t;

  rsp_t                rsp;
  logic                starved;
  logic                g0;
  logic                g1;
  logic                any_gnt;
  logic                sel_we;
  logic [DATA_W/8-1:0] sel_wmask;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rsp_data;

  assign starved = starve_cnt >= MAX_CNT;

  // m1 wins when alone or starved; grants are masked in reset
  always_comb begin
    g1 = reset & m1.req & (~m0.req | starved);
    g0 = reset & m0.req & ~g1;
  end

  assign any_gnt = g0 | g1;
  assign m0.gnt  = g0;
  assign m1.gnt  = g1;

  // steer the granted master onto the shared bus
  always_comb begin
    sel_we    = g1 ? m1.we    : m0.we;
    sel_wmask = g1 ? m1.wmask : m0.wmask;
    sel_addr  = g1 ? m1.addr  : m0.addr;
    sel_wdata = g1 ? m1.wdata : m0.wdata;
  end

  // bus drives live values on grant, else last granted ones
  always_comb begin
    mem_addr  = any_gnt ? sel_addr  : addr_q;
    mem_wdata = any_gnt ? sel_wdata : wdata_q;
    ram_wmask = '0;
    io_we     = 1'b0;
    if (any_gnt && sel_we) begin
      if (sel_addr[IO_BIT]) io_we = 1'b1;
      else                  ram_wmask = sel_wmask;
    end
  end

  // remember the last driven bus values while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (any_gnt) begin
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  // count consecutive cycles m1 loses to m0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (m1.req && g0) begin
      if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // capture who read and from where, presented next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp <= '0;
    end else begin
      rsp.valid <= any_gnt & ~sel_we;
      rsp.id    <= g1;
      rsp.tgt   <= sel_addr[IO_BIT];
    end
  end

  assign rsp_data  = rsp.tgt ? io_rdata : ram_rdata;
  assign m0.rvalid = rsp.valid & ~rsp.id;
  assign m1.rvalid = rsp.valid &  rsp.id;
  assign m0.rdata  = m0.rvalid ? rsp_data : '0;
  assign m1.rdata  = m1.rvalid ? rsp_data : '0;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Scoreboard bench for dmem_bus_arbiter.
// Read expectations are queued at grant and popped at response.
module tb_dmem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  dmem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

  logic [3:0]    ram_wmask;
  logic          io_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] io_rdata;
  logic [3:0]    starve_cnt;

  dmem_bus_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MAX_WAIT(MW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_if),
    .m1        (m1_if),
    .ram_wmask (ram_wmask),
    .io_we     (io_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .ram_rdata (ram_rdata),
    .io_rdata  (io_rdata),
    .starve_cnt(starve_cnt)
  );

  logic [31:0] ram [16];
  logic [31:0] io_reg;
  logic [3:0]  ridx;
  assign ridx = mem_addr[5:2];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_wmask[b]) ram[ridx][8*b+:8] <= mem_wdata[8*b+:8];
    if (io_we) io_reg <= mem_wdata;
    ram_rdata <= ram[ridx];
    io_rdata  <= io_reg;
  end

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          id;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq [$];
  logic [3:0]  sc;
  logic [31:0] exp_ram [16];
  logic [31:0] exp_io;

  task automatic drv(input bit r0, input bit we0,
                     input logic [3:0] wm0,
                     input logic [31:0] a0,
                     input logic [31:0] d0,
                     input bit r1, input bit we1,
                     input logic [3:0] wm1,
                     input logic [31:0] a1,
                     input logic [31:0] d1);
    m0_if.req = r0; m0_if.we = we0;
    m0_if.wmask = wm0; m0_if.addr = a0;
    m0_if.wdata = d0;
    m1_if.req = r1; m1_if.we = we1;
    m1_if.wmask = wm1; m1_if.addr = a1;
    m1_if.wdata = d1;
  endtask

  task automatic idle();
    drv(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic cycle();
    bit          g0, g1, g, we;
    logic [3:0]  m, xm;
    logic [31:0] a, d;
    exp_t        e;
    @(negedge clk);
    g1 = m1_if.req && (!m0_if.req || sc >= 4'(MW));
    g0 = m0_if.req && !g1;
    g  = g0 || g1;
    we = g1 ? m1_if.we    : m0_if.we;
    m  = g1 ? m1_if.wmask : m0_if.wmask;
    a  = g1 ? m1_if.addr  : m0_if.addr;
    d  = g1 ? m1_if.wdata : m0_if.wdata;
    chk("gnt0", 32'(m0_if.gnt), 32'(g0));
    chk("gnt1", 32'(m1_if.gnt), 32'(g1));
    chk("starve", 32'(starve_cnt), 32'(sc));
    xm = (g && we && !a[22]) ? m : 4'h0;
    chk("wmask", 32'(ram_wmask), 32'(xm));
    chk("io_we", 32'(io_we), 32'(g && we && a[22]));
    if (g) begin
      chk("addr", mem_addr, a);
      chk("wdata", mem_wdata, d);
      if (we) begin
        if (a[22]) exp_io = d;
        else
          for (int b = 0; b < 4; b++)
            if (m[b]) exp_ram[a[5:2]][8*b+:8] = d[8*b+:8];
      end else begin
        e.id   = g1;
        e.data = a[22] ? exp_io : exp_ram[a[5:2]];
        sbq.push_back(e);
      end
    end
    if (m1_if.req && g0) sc = (sc == 4'hF) ? sc : sc + 4'd1;
    else sc = 4'd0;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.id) begin
        chk("rv1", 32'(m1_if.rvalid), 32'd1);
        chk("rd1", m1_if.rdata, e.data);
        chk("rv0_off", 32'(m0_if.rvalid), 32'd0);
        chk("rd0_off", m0_if.rdata, 32'd0);
      end else begin
        chk("rv0", 32'(m0_if.rvalid), 32'd1);
        chk("rd0", m0_if.rdata, e.data);
        chk("rv1_off", 32'(m1_if.rvalid), 32'd0);
        chk("rd1_off", m1_if.rdata, 32'd0);
      end
    end else begin
      chk("rv0_idle", 32'(m0_if.rvalid), 32'd0);
      chk("rv1_idle", 32'(m1_if.rvalid), 32'd0);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_gnt0", 32'(m0_if.gnt), 32'd0);
    chk("rst_gnt1", 32'(m1_if.gnt), 32'd0);
    chk("rst_rv0", 32'(m0_if.rvalid), 32'd0);
    chk("rst_rv1", 32'(m1_if.rvalid), 32'd0);
    chk("rst_wmask", 32'(ram_wmask), 32'd0);
    chk("rst_io_we", 32'(io_we), 32'd0);
    chk("rst_starve", 32'(starve_cnt), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i] = 32'h0;
      exp_ram[i] = 32'h0;
    end
    io_reg = 32'h0;
    exp_io = 32'h0;
    sc = 4'd0;

    drv(1, 1, 4'hF, 32'h0000_0010, 32'hDEADBEEF,
        1, 1, 4'hF, 32'h0040_0000, 32'h1F);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outs();
    idle();
    @(posedge clk);
    #1;
    reset = 1'b1;

    drv(1, 1, 4'hF, 32'h0000_0010, 32'hDEADBEEF,
        0, 0, 4'h0, 32'h0, 32'h0);
    cycle();
    drv(1, 0, 4'h0, 32'h0000_0010, 32'h0,
        0, 0, 4'h0, 32'h0, 32'h0);
    cycle();
    drv(1, 1, 4'h3, 32'h0000_0010, 32'h0000_1234,
        0, 0, 4'h0, 32'h0, 32'h0);
    cycle();
    drv(1, 0, 4'h0, 32'h0000_0010, 32'h0,
        0, 0, 4'h0, 32'h0, 32'h0);
    cycle();

    drv(0, 0, 4'h0, 32'h0, 32'h0,
        1, 1, 4'hF, 32'h0040_0000, 32'h1F);
    cycle();
    drv(0, 0, 4'h0, 32'h0, 32'h0,
        1, 0, 4'h0, 32'h0040_0000, 32'h0);
    cycle();
    drv(0, 0, 4'h0, 32'h0, 32'h0,
        1, 1, 4'hF, 32'h0000_0020, 32'hA5A5_0F0F);
    cycle();
    idle();
    cycle();

    drv(1, 0, 4'h0, 32'h0000_0010, 32'h0,
        1, 0, 4'h0, 32'h0040_0000, 32'h0);
    repeat (11) cycle();
    drv(1, 1, 4'hF, 32'h0000_0024, 32'h1111_2222,
        1, 0, 4'h0, 32'h0000_0020, 32'h0);
    repeat (6) cycle();

    idle();
    cycle();
    drv(1, 0, 4'h0, 32'h0040_0000, 32'h0,
        0, 0, 4'h0, 32'h0, 32'h0);
    cycle();
    drv(0, 0, 4'h0, 32'h0, 32'h0,
        1, 0, 4'h0, 32'h0000_0024, 32'h0);
    cycle();
    drv(1, 0, 4'h0, 32'h0000_0020, 32'h0,
        0, 0, 4'h0, 32'h0, 32'h0);
    cycle();
    idle();
    cycle();

    drv(1, 0, 4'h0, 32'h0000_0010, 32'h0,
        0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mid_gnt0", 32'(m0_if.gnt), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outs();
    @(posedge clk);
    #1;
    chk_reset_outs();
    @(posedge clk);
    #1;
    chk("mid_rv0", 32'(m0_if.rvalid), 32'd0);
    idle();
    @(posedge clk);
    #1;
    reset = 1'b1;
    sc = 4'd0;
    sbq.delete();
    cycle();
    drv(1, 0, 4'h0, 32'h0000_0010, 32'h0,
        0, 0, 4'h0, 32'h0, 32'h0);
    cycle();
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
- Shares the single data-memory/IO port between two requesters: master 0 (core load/store unit) and master 1 (program-loader/debug DMA).
- Decodes the target by address bit 22: 0 = data RAM, 1 = IO.
- Issues at most one access per cycle and steers synchronous read data back to the requester that issued it.
- Sits between the core datapath and the data RAM / IO driver.

Parameters:
- ADDR_W, 32, address width of both masters and the memory side.
- DATA_W, 32, data width (byte mask width is DATA_W/8).
- MAX_WAIT, 4, consecutive cycles master 1 may lose to master 0 before it is forced to win (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- m0_req  in  1  master 0 access request; held with all m0_* inputs stable until m0_gnt.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_wmask  in  DATA_W/8  master 0 byte-write mask.
- m0_addr  in  ADDR_W  master 0 byte address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 access accepted this cycle (combinational).
- m0_rvalid  out  1  master 0 read data valid (registered).
- m0_rdata  out  DATA_W  master 0 read data.
- m1_req, m1_we, m1_wmask, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- ram_wmask  out  DATA_W/8  RAM byte write enables.
- io_we  out  1  IO write strobe.
- mem_addr  out  ADDR_W  shared address to RAM and IO.
- mem_wdata  out  DATA_W  shared write data.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after address.
- io_rdata  in  DATA_W  IO read data, valid one cycle after address.
- starve_cnt  out  4  current master 1 loss counter (debug).

Behaviour:
- Arbitration is combinational within the cycle:
  - Only one master requesting: that master is granted.
  - Both requesting: m0 wins unless starve_cnt >= MAX_WAIT, in which case m1 wins.
  - m0_gnt and m1_gnt are never both 1.
- starve_cnt register:
  - Increments when m1_req=1 and m0 is granted (saturates at 15).
  - Clears to 0 when m1 is granted, or in any cycle with m1_req=0.
- Granted master drives mem_addr and mem_wdata. When nothing is granted, these hold their previous value and all write strobes are 0.
- Write, granted with we=1:
  - addr[22]=0: ram_wmask = wmask, io_we = 0.
  - addr[22]=1: io_we = 1, ram_wmask = 0.
  - Write completes in the grant cycle; no rvalid is generated.
- Read, granted with we=0:
  - Both write strobes are 0.
  - A response register captures {valid, master id, target = addr[22]}.
  - Next cycle: that master's rvalid = 1 for exactly one cycle, and its rdata = ram_rdata or io_rdata according to the captured target.
  - The other master's rvalid = 0 and its rdata = 0.
- Read latency is 1 cycle from grant. Back-to-back grants are allowed every cycle; responses follow in issue order, one per cycle.
- Simultaneous: a new grant in the same cycle as a pending response is legal; the response register is overwritten at the clock edge after the old response has been presented.
- Reset asserted (reset=0) at any time, including mid-access:
  - starve_cnt = 0, response valid = 0, m0_rvalid = m1_rvalid = 0.
  - mem_addr = 0, mem_wdata = 0, ram_wmask = 0, io_we = 0.
  - gnt outputs forced to 0 while in reset.
  - Any in-flight read response is dropped, never delivered.
- After reset deasserts, the first rising edge may grant.

Test Plan:
- Reset check: hold reset=0 with both reqs high -> both gnt=0, all rvalid=0, ram_wmask=0, io_we=0, starve_cnt=0.
- m0 write: addr 0x0000_0010, wdata 0xDEADBEEF, wmask 0xF -> same cycle m0_gnt=1, ram_wmask=0xF, io_we=0. Then m0 read of the same addr -> next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF.
- IO decode: m1 write addr 0x0040_0000, wdata 0x1F -> io_we=1, ram_wmask=0. m1 read of the same addr with io_rdata=0x1F -> m1_rvalid=1, m1_rdata=0x1F, m0_rvalid=0.
- Starvation, MAX_WAIT=4: both reqs held continuously -> m0 granted for cycles 1-4 with starve_cnt 1..4; cycle 5 m1_gnt=1 and starve_cnt returns to 0; pattern repeats.
- Back-to-back reads: m0 reads A in cycle n and m1 reads B in cycle n+1 -> m0_rvalid in n+1, m1_rvalid in n+2, each carrying the correct data, with no overlap.
- Reset mid-read: m0 granted a read, reset=0 asserted before the next edge -> m0_rvalid never pulses; after release, a fresh read returns normally with 1-cycle latency.
